// File: rtl/imager_stream_framer.sv
// Turns raw imager fv/lv/dat timing into a dvi/dtype/data word stream with frame/row flags,
// and reports per-frame statistics (count, rows, columns, row-length consistency).
module imager_stream_framer #(
  parameter int unsigned DATA_WIDTH     = 10,
  parameter int unsigned DTYPE_WIDTH    = 8,
  parameter int unsigned NUM_ROWS_WIDTH = 12,
  parameter int unsigned NUM_COLS_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic                      fv,
  input  logic                      lv,
  input  logic [DATA_WIDTH-1:0]     dat,
  output logic                      dvo,
  output logic [DTYPE_WIDTH-1:0]    dtypeo,
  output logic [DATA_WIDTH-1:0]     datao,
  output logic [15:0]               frame_count,
  output logic [NUM_ROWS_WIDTH-1:0] num_rows,
  output logic [NUM_COLS_WIDTH-1:0] num_cols,
  output logic                      row_len_err
);

  localparam int unsigned FC_WIDTH = 16;
  localparam logic [4:0]  DT_FRAME_END = 5'h10;

  // input pipeline: s0 = sampled inputs, s1 = previous s0, lv2 = lv one cycle before s1
  logic                  fv0, lv0, fv1, lv1, lv2;
  logic [DATA_WIDTH-1:0] dat0, dat1;
  logic                  s0_vld;

  // frame tracking state
  logic                      armed, active, pending, first_pix, err_w;
  logic [NUM_ROWS_WIDTH-1:0] row_cnt;
  logic [NUM_COLS_WIDTH-1:0] col_cnt, first_len;

  logic                      armed_nxt, active_nxt, pending_nxt, first_nxt, err_nxt;
  logic [NUM_ROWS_WIDTH-1:0] row_nxt;
  logic [NUM_COLS_WIDTH-1:0] col_nxt, flen_nxt;

  logic                      dvo_nxt, rle_nxt;
  logic [DTYPE_WIDTH-1:0]    dtype_nxt;
  logic [DATA_WIDTH-1:0]     data_nxt;
  logic [FC_WIDTH-1:0]       fc_nxt;
  logic [NUM_ROWS_WIDTH-1:0] nr_nxt;
  logic [NUM_COLS_WIDTH-1:0] nc_nxt;

  logic rise_c, pix_c, fall_c, mark_c, row_start_c, row_end_c;

  assign rise_c      = armed & fv0 & ~fv1;
  assign pix_c       = active & fv1 & lv1;
  assign fall_c      = active & fv1 & ~fv0;
  assign mark_c      = pending | (fall_c & ~lv1);
  // a row starts on an lv rise; the first pixel of a frame always counts as a row start
  assign row_start_c = pix_c & (~lv2 | first_pix);
  assign row_end_c   = pix_c & (~lv0 | ~fv0);

  always_comb begin
    armed_nxt   = armed | (s0_vld & ~fv0);
    active_nxt  = active;
    pending_nxt = fall_c & lv1;
    first_nxt   = first_pix;
    err_nxt     = err_w;
    row_nxt     = row_cnt;
    col_nxt     = col_cnt;
    flen_nxt    = first_len;
    dvo_nxt     = 1'b0;
    dtype_nxt   = '0;
    data_nxt    = '0;
    fc_nxt      = frame_count;
    nr_nxt      = num_rows;
    nc_nxt      = num_cols;
    rle_nxt     = row_len_err;

    if (pix_c) begin
      dvo_nxt   = 1'b1;
      data_nxt  = dat1;
      dtype_nxt = DTYPE_WIDTH'({row_end_c, row_start_c, first_pix, 1'b1});
      first_nxt = 1'b0;
      if (row_start_c)
        col_nxt = NUM_COLS_WIDTH'(1);
      else if (col_cnt != '1)
        col_nxt = col_cnt + NUM_COLS_WIDTH'(1);
      if (row_end_c) begin
        if (row_cnt != '1)
          row_nxt = row_cnt + NUM_ROWS_WIDTH'(1);
        if (row_cnt == '0)
          flen_nxt = col_nxt;
        else if (col_nxt != first_len)
          err_nxt = 1'b1;
      end
    end

    // FRAME_END marker publishes the statistics gathered over the frame
    if (mark_c) begin
      dvo_nxt    = 1'b1;
      dtype_nxt  = DTYPE_WIDTH'(DT_FRAME_END);
      data_nxt   = DATA_WIDTH'(row_cnt);
      fc_nxt     = frame_count + FC_WIDTH'(1);
      nr_nxt     = row_cnt;
      nc_nxt     = col_cnt;
      rle_nxt    = err_w;
      active_nxt = 1'b0;
    end

    // acceptance comes last so a new frame overrides the marker's active clear
    if (rise_c) begin
      active_nxt = enable;
      first_nxt  = 1'b1;
      err_nxt    = 1'b0;
      row_nxt    = '0;
      col_nxt    = '0;
      flen_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fv0         <= 1'b0;
      lv0         <= 1'b0;
      dat0        <= '0;
      fv1         <= 1'b0;
      lv1         <= 1'b0;
      dat1        <= '0;
      lv2         <= 1'b0;
      s0_vld      <= 1'b0;
      armed       <= 1'b0;
      active      <= 1'b0;
      pending     <= 1'b0;
      first_pix   <= 1'b0;
      err_w       <= 1'b0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      first_len   <= '0;
      dvo         <= 1'b0;
      dtypeo      <= '0;
      datao       <= '0;
      frame_count <= '0;
      num_rows    <= '0;
      num_cols    <= '0;
      row_len_err <= 1'b0;
    end else begin
      fv0         <= fv;
      lv0         <= lv;
      dat0        <= dat;
      fv1         <= fv0;
      lv1         <= lv0;
      dat1        <= dat0;
      lv2         <= lv1;
      s0_vld      <= 1'b1;
      armed       <= armed_nxt;
      active      <= active_nxt;
      pending     <= pending_nxt;
      first_pix   <= first_nxt;
      err_w       <= err_nxt;
      row_cnt     <= row_nxt;
      col_cnt     <= col_nxt;
      first_len   <= flen_nxt;
      dvo         <= dvo_nxt;
      dtypeo      <= dtype_nxt;
      datao       <= data_nxt;
      frame_count <= fc_nxt;
      num_rows    <= nr_nxt;
      num_cols    <= nc_nxt;
      row_len_err <= rle_nxt;
    end
  end

endmodule

// File: tb/tb_imager_stream_framer.sv
// Scoreboard bench for imager_stream_framer: frames are described by row lengths, expected
// words (with their output edge) are queued at drive time and matched against dvo words.
module tb_imager_stream_framer;

  localparam int unsigned DW = 10;
  localparam int unsigned TW = 8;
  localparam int unsigned RW = 12;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          resetb, enable, fv, lv;
  logic [DW-1:0] dat;
  logic          dvo, row_len_err;
  logic [TW-1:0] dtypeo;
  logic [DW-1:0] datao;
  logic [15:0]   frame_count;
  logic [RW-1:0] num_rows;
  logic [CW-1:0] num_cols;

  imager_stream_framer #(
    .DATA_WIDTH(DW), .DTYPE_WIDTH(TW), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CW)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .fv(fv), .lv(lv), .dat(dat),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .frame_count(frame_count),
    .num_rows(num_rows), .num_cols(num_cols), .row_len_err(row_len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at;
    logic [TW-1:0] dtype;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  int   exp_fc   = 0;
  int   row_len[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // inputs change on the falling edge; 'at' is the rising edge that samples them
  task automatic drive(input logic f, input logic l, input logic [DW-1:0] d, output int at);
    @(negedge clk);
    fv  = f;
    lv  = l;
    dat = d;
    at  = edge_n + 1;
  endtask

  task automatic push(input int at, input int dt, input int data);
    exp_t x;
    x.at    = at;
    x.dtype = TW'(dt);
    x.data  = DW'(data);
    sb.push_back(x);
  endtask

  // front porch 2, rows from row_len[] with 2-cycle lv gaps, back porch 4
  task automatic send_frame(input int nrows, input bit together, input bit drop);
    int at;
    int dt;
    bit first;
    first  = 1'b1;
    enable = !drop;
    drive(1'b1, 1'b0, '0, at);
    drive(1'b1, 1'b0, '0, at);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < row_len[r]; c++) begin
        drive(1'b1, 1'b1, DW'(r * 16 + c), at);
        dt = 1 | (first ? 2 : 0) | (c == 0 ? 4 : 0) | (c == row_len[r] - 1 ? 8 : 0);
        if (!drop) begin
          push(at + 2, dt, r * 16 + c);
          first = 1'b0;
        end
      end
      if (!(together && r == nrows - 1)) begin
        drive(1'b1, 1'b0, '0, at);
        drive(1'b1, 1'b0, '0, at);
      end
      if (drop) enable = 1'b1;
    end
    drive(1'b0, 1'b0, '0, at);
    if (!drop) begin
      push(at + ((together && nrows > 0) ? 2 : 1), 'h10, nrows);
      exp_fc++;
    end
    repeat (3) drive(1'b0, 1'b0, '0, at);
  endtask

  task automatic check_stats(input string tag, input int nr, input int nc, input int err);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
    chk({tag, "_num_rows"}, 32'(num_rows), 32'(nr));
    chk({tag, "_num_cols"}, 32'(num_cols), 32'(nc));
    chk({tag, "_row_len_err"}, 32'(row_len_err), 32'(err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dvo"}, 32'(dvo), 32'd0);
    chk({tag, "_dtypeo"}, 32'(dtypeo), 32'd0);
    chk({tag, "_datao"}, 32'(datao), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_num_rows"}, 32'(num_rows), 32'd0);
    chk({tag, "_num_cols"}, 32'(num_cols), 32'd0);
    chk({tag, "_row_len_err"}, 32'(row_len_err), 32'd0);
  endtask

  // output monitor: every dvo word must match the queue head at its expected edge
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    #1;
    if (mon_en) begin
      if (dvo) begin
        if (sb.size() == 0) begin
          chk("unexpected_dvo", 32'(dvo), 32'd0);
        end else begin
          got_e = sb.pop_front();
          chk("dtypeo", 32'(dtypeo), 32'(got_e.dtype));
          chk("datao", 32'(datao), 32'(got_e.data));
          chk("latency_edge", 32'(edge_n), 32'(got_e.at));
        end
      end else begin
        chk("idle_zero", 32'({dtypeo, datao}), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    resetb = 1'b0;
    enable = 1'b0;
    fv     = 1'b0;
    lv     = 1'b0;
    dat    = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetb = 1'b1;
    mon_en = 1'b1;
    repeat (4) drive(1'b0, 1'b0, '0, e);

    row_len = '{4, 4, 4, 0, 0, 0, 0, 0};
    send_frame(3, 1'b0, 1'b0);
    check_stats("f4x3", 3, 4, 0);

    send_frame(3, 1'b0, 1'b1);
    chk("drop_frame_count", 32'(frame_count), 32'd1);

    row_len = '{5, 5, 0, 0, 0, 0, 0, 0};
    send_frame(2, 1'b0, 1'b0);
    check_stats("after_drop", 2, 5, 0);

    row_len = '{1, 1, 1, 1, 0, 0, 0, 0};
    send_frame(4, 1'b1, 1'b0);
    check_stats("onecol", 4, 1, 0);

    row_len = '{4, 4, 3, 0, 0, 0, 0, 0};
    send_frame(3, 1'b0, 1'b0);
    check_stats("uneven", 3, 3, 1);

    row_len = '{3, 3, 0, 0, 0, 0, 0, 0};
    send_frame(2, 1'b0, 1'b0);
    check_stats("clean", 2, 3, 0);

    repeat (3) drive(1'b0, 1'b1, DW'(7), e);
    repeat (2) drive(1'b0, 1'b0, '0, e);
    check_stats("lv_no_fv", 2, 3, 0);

    send_frame(0, 1'b0, 1'b0);
    check_stats("zero_row", 0, 0, 0);

    // reset asserted mid-row and released while fv is still high
    chk("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    enable = 1'b1;
    drive(1'b1, 1'b0, '0, e);
    drive(1'b1, 1'b0, '0, e);
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, DW'(c), e);
    repeat (2) drive(1'b1, 1'b0, '0, e);
    drive(1'b1, 1'b1, DW'(16), e);
    drive(1'b1, 1'b1, DW'(17), e);
    @(posedge clk);
    #2 resetb = 1'b0;
    #1 check_zero("async_reset");
    exp_fc = 0;
    mon_en = 1'b1;
    drive(1'b1, 1'b1, DW'(18), e);
    resetb = 1'b1;
    drive(1'b1, 1'b1, DW'(19), e);
    repeat (2) drive(1'b1, 1'b0, '0, e);
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, DW'(32 + c), e);
    repeat (2) drive(1'b1, 1'b0, '0, e);
    repeat (4) drive(1'b0, 1'b0, '0, e);
    check_stats("ignored_frame", 0, 0, 0);

    row_len = '{4, 4, 4, 0, 0, 0, 0, 0};
    send_frame(3, 1'b0, 1'b0);
    check_stats("post_reset", 3, 4, 0);

    repeat (5) drive(1'b0, 1'b0, '0, e);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
